// File: rtl/ram_master_if.sv
// Host-side handshake bundle of ram_master: command, write-data stream, read return, done.
// Pure wiring, no latency; the host owns *_valid, ram_master owns *_ready/rdata/done.
// Optional cmd_err exists only when RAM_MASTER_RANGE_CHK_EN is defined.
interface ram_master_if #(
  parameter int M = 8,
  parameter int A = 7,
  parameter int L = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_wr;
  logic [A-1:0] cmd_addr;
  logic [L-1:0] cmd_len;
  logic [M-1:0] wdata;
  logic         wdata_valid;
  logic         wdata_ready;
  logic [M-1:0] rdata;
  logic         rdata_valid;
  logic         done;
`ifdef RAM_MASTER_RANGE_CHK_EN
  logic         cmd_err;
`endif

  // Host side
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wdata_valid,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done
`ifdef RAM_MASTER_RANGE_CHK_EN
    , input cmd_err
`endif
  );

  // ram_master side
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wdata_valid,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done
`ifdef RAM_MASTER_RANGE_CHK_EN
    , output cmd_err
`endif
  );
endinterface

// File: rtl/ram_master.sv
// Bus initiator for the shared tri-state RAM: single/burst reads and writes from a host.
// Latency: write word = 3 cycles after wdata accept; read word valid RD_WAIT+1 cycles after R_SETUP.
// Backpressure: cmd_ready only in IDLE; wdata stalls the burst in W_WAIT with the RAM deselected.
// Optional range check on start address: RAM_MASTER_RANGE_CHK_EN.
module ram_master #(
  parameter int M       = 8,
  parameter int A       = 7,
  parameter int DEPTH   = 69,
  parameter int L       = 4,
  parameter int RD_WAIT = 1
) (
  input  logic         clk1,
  input  logic         rst_n,
  ram_master_if.slave  host,
  output logic [A-1:0] address_r,
  output logic         writeEn,
  output logic         act_ram,
  output logic         d,
  inout  wire  [M-1:0] data
);

  localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [3:0] {
    IDLE, W_WAIT, W_SETUP, W_STROBE, W_HOLD,
    R_SETUP, R_WAIT, R_SAMPLE, DONE, W_DRAIN
  } state_t;

  state_t        state_q;
  logic [A-1:0]  addr_q;
  logic [A-1:0]  addr_d;
  logic [L-1:0]  cnt_q;
  logic [WW-1:0] wait_q;
  logic [M-1:0]  wdat_q;
  logic [M-1:0]  rdata_q;
  logic          we_q;
  logic          act_q;
  logic          d_q;
  logic          rvld_q;
  logic          done_q;
  logic          last_word;
`ifdef RAM_MASTER_RANGE_CHK_EN
  logic          err_q;
  logic          cmd_oor;

  assign cmd_oor      = 32'(host.cmd_addr) >= DEPTH;
  assign host.cmd_err = err_q;
  // Out-of-range writes still drain their words so the host stream stays aligned
  assign host.wdata_ready = host.wdata_valid && ((state_q == W_WAIT) || (state_q == W_DRAIN));
`else
  assign host.wdata_ready = host.wdata_valid && (state_q == W_WAIT);
`endif

  assign host.cmd_ready   = (state_q == IDLE);
  assign host.rdata       = rdata_q;
  assign host.rdata_valid = rvld_q;
  assign host.done        = done_q;

  assign address_r = addr_q;
  assign writeEn   = we_q;
  assign act_ram   = act_q;
  assign d         = d_q;

  // Bus is only ours while the RAM is selected for a write; otherwise it is released
  assign data = (we_q && act_q) ? wdat_q : {M{1'bz}};

  assign last_word = (cnt_q == '0);

  // Next burst address wraps at the last physical location, not at 2^A
  always_comb begin
    addr_d = addr_q + 1'b1;
    if (addr_q == A'(DEPTH - 1)) addr_d = '0;
  end

  // Single FSM: sequences the RAM strobes and registers every RAM-side and pulse output
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      act_q   <= 1'b0;
      d_q     <= 1'b0;
      rvld_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RAM_MASTER_RANGE_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      d_q    <= 1'b0;
      rvld_q <= 1'b0;
      done_q <= 1'b0;
`ifdef RAM_MASTER_RANGE_CHK_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (host.cmd_valid) begin
            addr_q <= host.cmd_addr;
            cnt_q  <= host.cmd_len;
`ifdef RAM_MASTER_RANGE_CHK_EN
            if (cmd_oor) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= host.cmd_wr ? W_DRAIN : DONE;
            end else
`endif
            if (host.cmd_wr) begin
              state_q <= W_WAIT;
            end else begin
              act_q   <= 1'b1;
              state_q <= R_SETUP;
            end
          end
        end
        W_WAIT: begin
          if (host.wdata_valid) begin
            wdat_q  <= host.wdata;
            we_q    <= 1'b1;
            act_q   <= 1'b1;
            state_q <= W_SETUP;
          end
        end
        W_SETUP: begin
          d_q     <= 1'b1;
          state_q <= W_STROBE;
        end
        W_STROBE: begin
          state_q <= W_HOLD;
        end
        W_HOLD: begin
          // Deselect between words so a stalled wdata stream leaves the RAM idle
          we_q  <= 1'b0;
          act_q <= 1'b0;
          if (last_word) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            addr_q  <= addr_d;
            state_q <= W_WAIT;
          end
        end
        R_SETUP: begin
          wait_q  <= WW'(RD_WAIT - 1);
          state_q <= R_WAIT;
        end
        R_WAIT: begin
          if (wait_q == '0) begin
            rdata_q <= data;
            rvld_q  <= 1'b1;
            state_q <= R_SAMPLE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        R_SAMPLE: begin
          if (last_word) begin
            act_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            addr_q  <= addr_d;
            state_q <= R_SETUP;
          end
        end
        DONE: begin
          // Turnaround cycle: RAM deselected, bus released, no command accepted
          state_q <= IDLE;
        end
`ifdef RAM_MASTER_RANGE_CHK_EN
        W_DRAIN: begin
          if (host.wdata_valid) begin
            if (last_word) state_q <= IDLE;
            else           cnt_q   <= cnt_q - 1'b1;
          end
        end
`endif
        default: begin
          we_q    <= 1'b0;
          act_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Bus initiator that drives the shared tri-state RAM interface: address_r, writeEn, act_ram, d and the bidirectional data bus.
- Accepts single or burst read/write commands from a host over a valid/ready handshake.
- Sequences the RAM strobes with guaranteed bus turnaround, and returns read data with a per-word valid pulse.
- Sits between the control logic and the RAM; it is the only driver of the RAM control pins.

Parameters:
- M, 8, data width in bits
- A, 7, address width in bits
- DEPTH, 69, number of RAM locations (valid addresses 0..DEPTH-1)
- L, 4, burst length field width; burst = cmd_len+1 words (1..2^L)
- RD_WAIT, 1, cycles between read address setup and data sample (>=1)

Ports:
- clk1  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  high in IDLE only; transfer when cmd_valid&&cmd_ready
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  A  start address
- cmd_len  in  L  words minus one
- wdata  in  M  write word
- wdata_valid  in  1  write word valid
- wdata_ready  out  1  pulses 1 cycle when the current wdata is consumed
- rdata  out  M  read word, held until next read sample
- rdata_valid  out  1  1-cycle pulse per read word
- done  out  1  1-cycle pulse after last word of a burst
- address_r  out  A  RAM address
- writeEn  out  1  RAM write enable
- act_ram  out  1  RAM select
- d  out  1  RAM write strobe
- data  inout  M  RAM data bus; driven only when writeEn&&act_ram

Behaviour:
- Reset (async assert, sync release): state=IDLE. address_r=0, writeEn=0, act_ram=0, d=0. data bus high-Z. cmd_ready=1, wdata_ready=0, rdata=0, rdata_valid=0, done=0.
- Command accept: latch addr, remaining count=cmd_len, and direction.
- Write path, per word: W_WAIT → W_SETUP → W_STROBE → W_HOLD.
  - W_WAIT: wait for wdata_valid; on it, latch wdata and pulse wdata_ready.
  - W_SETUP: drive address_r, data, writeEn=1, act_ram=1, d=0.
  - W_STROBE: d=1.
  - W_HOLD: d=0; address and data held stable.
  - Each write word takes 3 cycles after wdata accept.
- Read path, per word: R_SETUP → RD_WAIT cycles → R_SAMPLE.
  - R_SETUP: drive address_r, act_ram=1, writeEn=0; master data driver high-Z.
  - After RD_WAIT cycles, R_SAMPLE captures data into rdata and pulses rdata_valid.
  - Latency from R_SETUP to rdata_valid = RD_WAIT+1 cycles.
- Burst: after each word, address increments. DEPTH-1 wraps to 0 (not 2^A). Count decrements; the last word goes to DONE.
- DONE: act_ram=0, writeEn=0, d=0, bus released. done pulses 1 cycle; return to IDLE.
  - DONE is the mandatory turnaround cycle, so writeEn never changes while act_ram=1 across commands.
- A new command cannot be accepted in the DONE cycle. Back-to-back commands are separated by at least DONE+IDLE.
- d is never high unless writeEn=1 and act_ram=1, and address_r never changes while d=1.
- Master must never drive data while writeEn=0. No cycle exists where master and RAM both drive the bus.
- wdata_valid low mid-burst: stay in W_WAIT with act_ram=0. Burst resumes on the next valid.
- cmd_valid during a busy burst: ignored (cmd_ready=0).
- Reset mid-operation: all RAM controls deassert immediately (async); the bus goes high-Z; the burst is abandoned with no done.

Optional Feature:
- Macro RAM_MASTER_RANGE_CHK_EN.
- Defined: adds output cmd_err (1 bit, reset 0).
  - A command with cmd_addr >= DEPTH is accepted but performs no RAM access (act_ram stays 0).
  - cmd_err and done pulse together one cycle after accept.
  - Write bursts still consume cmd_len+1 wdata words so the host stream stays aligned.
- Undefined: no cmd_err port. Out-of-range addresses are passed through unchecked.

Test Plan:
- Single write addr=5, wdata=0xA5 → writeEn/act_ram high 3 cycles, d high exactly 1 cycle with address_r=5, data=0xA5; done 1 cycle after W_HOLD.
- Single read addr=5 after that write, RD_WAIT=1 → rdata_valid 2 cycles after R_SETUP, rdata=0xA5; data bus not driven by master throughout.
- Write burst addr=67, len=3, data 0x11,0x22,0x33,0x44 → writes hit 67,68,0,1; read burst same range returns the same four values in order.
- Write burst len=1 with wdata_valid low 4 cycles between words → act_ram=0 during gap; both words stored correctly; one done pulse.
- Assert rst_n=0 during W_STROBE of a burst → d, writeEn, act_ram drop same cycle, bus high-Z, no done; next command executes normally.
- With RAM_MASTER_RANGE_CHK_EN: read addr=100 → act_ram never asserts; cmd_err and done pulse together one cycle after accept.
